reg_bank: RTL

//  - General-purpose register file plus status (flag) register of the single-cycle datapath.
//  - Sits directly upstream of the ALU:
//    - ports A/B drive the ALU val_a/val_b;
//    - the ALU result is written back here;
//    - the ALU zero/carry/negative outputs are latched into a status register for branch logic.

---
 rtl/reg_bank_pkg.sv | 38 +++
 rtl/reg_bank_if.sv | 36 +++
 rtl/reg_flags.sv | 32 +++
 rtl/reg_bank.sv | 103 ++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared definitions for the register bank, the ALU and the
// branch unit.
//   DATA_W_DEF / ADDR_W_DEF : default operand and address widths
//   FLG_Z / FLG_C / FLG_N    : bit positions of zero / carry / negative flags
//   FLAG_RST                 : status register reset value (zero flag set)
//   addr_ok()                : true when an address maps to a writable,
//                              readable (non-hardwired) register
package reg_bank_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;

  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_N = 2;

  localparam logic [2:0] FLAG_RST = 3'b001;

  typedef logic [2:0] flags_t;

  // An address is live when it is inside the array and is not the
  // hardwired-zero slot.
  function automatic logic addr_ok(input int unsigned addr,
                                   input int unsigned num_regs,
                                   input logic        zero_reg);
    logic ok;
    ok = 1'b1;
    if (addr >= num_regs) begin
      ok = 1'b0;
    end else if (zero_reg && (addr == 32'd0)) begin
      ok = 1'b0;
    end else begin
      ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/reg_bank_if.sv
// reg_bank_if: bus bundle between the register bank and its datapath user.
//   Read ports A/B (address in, data out), write-back port, and the
//   ALU flag inputs / latched flag outputs.
//   slave  : register bank side
//   master : datapath / controller side
interface reg_bank_if #(
  parameter int DATA_W = reg_bank_pkg::DATA_W_DEF,
  parameter int ADDR_W = reg_bank_pkg::ADDR_W_DEF
);
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              flag_we;
  logic              zero_in;
  logic              carry_in;
  logic              neg_in;
  logic              zero_q;
  logic              carry_q;
  logic              neg_q;

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
    input  flag_we, zero_in, carry_in, neg_in,
    output rd_data_a, rd_data_b, zero_q, carry_q, neg_q
  );

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
    output flag_we, zero_in, carry_in, neg_in,
    input  rd_data_a, rd_data_b, zero_q, carry_q, neg_q
  );
endinterface

// File: rtl/reg_flags.sv
// reg_flags: 3-bit status register (zero/carry/negative).
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset, loads FLAG_RST
//   i_load  : load enable
//   i_flags : new flag vector (bit order FLG_Z/FLG_C/FLG_N)
//   o_flags : latched flag vector
module reg_flags
  import reg_bank_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_load,
  input  flags_t i_flags,
  output flags_t o_flags
);

  flags_t r_flags;

  // Status register: reset has priority over load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flags <= FLAG_RST;
    end else if (i_load) begin
      r_flags <= i_flags;
    end else begin
      r_flags <= r_flags;
    end
  end

  assign o_flags = r_flags;

endmodule

// File: rtl/reg_bank.sv
// reg_bank: general-purpose register file plus status register.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset (registers -> 0, flags -> FLAG_RST)
//   bus   : reg_bank_if.slave - two combinational read ports, one write-back
//           port, flag load and latched flag outputs
// Optional feature: define REG_BANK_BYPASS_EN to forward a legal same-cycle
// write to any read port addressing the written register.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  reg_bank_if.slave   bus
);

  if (NUM_REGS > (2 ** ADDR_W)) begin : g_bad_params
    $error("reg_bank: NUM_REGS exceeds 2**ADDR_W");
  end

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_wr_ok;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  flags_t            w_flags_in;
  flags_t            w_flags_q;

  assign w_wr_ok = bus.wr_en &&
                   addr_ok(32'(bus.wr_addr), NUM_REGS, (ZERO_REG != 0));

  // Register array: reset clears all, otherwise legal writes update one slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!rst_n) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end else if (w_wr_ok && (bus.wr_addr == ADDR_W'(i))) begin
        r_regs[i] <= bus.wr_data;
      end else begin
        r_regs[i] <= r_regs[i];
      end
    end
  end

  // Read muxes: dead addresses (out of range / hardwired zero) read as 0.
  always_comb begin
    w_rd_a = {DATA_W{1'b0}};
    w_rd_b = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if ((bus.rd_addr_a == ADDR_W'(i)) &&
          addr_ok(32'(i), NUM_REGS, (ZERO_REG != 0))) begin
        w_rd_a = r_regs[i];
      end else begin
        w_rd_a = w_rd_a;
      end
      if ((bus.rd_addr_b == ADDR_W'(i)) &&
          addr_ok(32'(i), NUM_REGS, (ZERO_REG != 0))) begin
        w_rd_b = r_regs[i];
      end else begin
        w_rd_b = w_rd_b;
      end
    end
`ifdef REG_BANK_BYPASS_EN
    // Write-through: only legal writes forward, so dead slots still read 0.
    if (w_wr_ok && (bus.rd_addr_a == bus.wr_addr)) begin
      w_rd_a = bus.wr_data;
    end else begin
      w_rd_a = w_rd_a;
    end
    if (w_wr_ok && (bus.rd_addr_b == bus.wr_addr)) begin
      w_rd_b = bus.wr_data;
    end else begin
      w_rd_b = w_rd_b;
    end
`endif
  end

  // Pack ALU flags into the shared bit order.
  always_comb begin
    w_flags_in        = 3'b000;
    w_flags_in[FLG_Z] = bus.zero_in;
    w_flags_in[FLG_C] = bus.carry_in;
    w_flags_in[FLG_N] = bus.neg_in;
  end

  reg_flags u_flags (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (bus.flag_we),
    .i_flags (w_flags_in),
    .o_flags (w_flags_q)
  );

  assign bus.rd_data_a = w_rd_a;
  assign bus.rd_data_b = w_rd_b;
  assign bus.zero_q    = w_flags_q[FLG_Z];
  assign bus.carry_q   = w_flags_q[FLG_C];
  assign bus.neg_q     = w_flags_q[FLG_N];

endmodule
